tlb_miss_requester: RTL

// Fully-associative TLB for one pipeline client (I-side or D-side) that initiates page walks to the MMU.

---
 rtl/mmu_pkg.sv | 34 +++
 rtl/tlb_cam.sv | 47 ++++
 rtl/tlb_miss_requester.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU/TLB types: permission bits, TLB entry layout and the miss-requester state encoding.
package mmu_pkg;

   localparam int unsigned PAGE_SHIFT = 12;
   localparam int unsigned VADDR_W    = 64;
   localparam int unsigned VPN_W      = VADDR_W - PAGE_SHIFT;
   localparam int unsigned PERM_W     = 8;

   // Ordered so the packed value matches the MMU's {D,A,G,U,X,W,R,V} byte
   typedef struct packed {
      logic d;
      logic a;
      logic g;
      logic u;
      logic x;
      logic w;
      logic r;
      logic v;
   } tlb_perm_bits;

   typedef struct packed {
      logic             valid;
      logic [VPN_W-1:0] vpn;
      logic [VPN_W-1:0] ppn;
      tlb_perm_bits     perms;
   } tlb_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_FAULT = 2'd2
   } tlb_state_e;

endpackage

// File: rtl/tlb_cam.sv
// Fully-associative TLB entry array: parallel VPN match, one-hot hit vector,
// single write port and flash-clear of all valid bits (clear beats a same-cycle write).
module tlb_cam
   import mmu_pkg::*;
#(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [VPN_W-1:0]   lookup_vpn_i,
   input  logic               clear_i,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  tlb_entry_t         wr_entry_i,
   output logic [ENTRIES-1:0] hit_vec_o,
   output tlb_entry_t         hit_entry_o
);

   tlb_entry_t entries_q [ENTRIES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) entries_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < int'(ENTRIES); i++) entries_q[i].valid <= 1'b0;
      end else if (wr_en_i) begin
         entries_q[wr_idx_i] <= wr_entry_i;
      end
   end

   always_comb begin
      hit_vec_o = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         hit_vec_o[i] = entries_q[i].valid && (entries_q[i].vpn == lookup_vpn_i);
      end
   end

   // At most one entry matches, so an OR of the selected entries is the mux
   always_comb begin
      hit_entry_o = '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         if (hit_vec_o[i]) hit_entry_o = hit_entry_o | entries_q[i];
      end
   end

endmodule

// File: rtl/tlb_miss_requester.sv
// Single-client TLB: same-cycle hit/permission check, one outstanding page walk on miss,
// round-robin install of successful walks, uncached reporting of walk faults.
module tlb_miss_requester
   import mmu_pkg::*;
#(
   parameter int unsigned ENTRIES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                lookup_valid,
   input  logic [VADDR_W-1:0]  lookup_vaddr,
   input  logic                lookup_is_write,
   input  logic                lookup_is_exec,
   output logic                lookup_resp_valid,
   output logic [VADDR_W-1:0]  lookup_paddr,
   output logic                lookup_fault,
   input  logic                flush,
   input  logic [VADDR_W-1:0]  root_pt_addr,
   output logic                mmu_req_valid,
   output logic [VADDR_W-1:0]  mmu_req_addr,
   input  logic                mmu_resp_valid,
   input  logic [VADDR_W-1:0]  mmu_resp_addr,
   input  logic [PERM_W-1:0]   mmu_resp_perms
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   tlb_state_e          state_q, state_d;
   logic [VPN_W-1:0]    req_vpn_q, req_vpn_d;
   logic [IDX_W-1:0]    victim_q, victim_d;
   logic [VADDR_W-1:0]  root_q;
   logic [VPN_W-1:0]    lookup_vpn;
   logic [ENTRIES-1:0]  hit_vec;
   tlb_entry_t          hit_entry;
   tlb_entry_t          wr_entry;
   tlb_perm_bits        resp_perms;
   logic                wr_en;
   logic                flush_any;
   logic                perm_ok;
   logic                resp_valid_c;
   logic                resp_fault_c;
   logic [VADDR_W-1:0]  resp_paddr_c;
   logic                unused_ok;

   assign lookup_vpn = lookup_vaddr[VADDR_W-1:PAGE_SHIFT];
   assign resp_perms = tlb_perm_bits'(mmu_resp_perms);
   // A root change acts exactly like an explicit flush
   assign flush_any  = flush | (root_pt_addr != root_q);
   assign wr_entry   = '{valid: 1'b1, vpn: req_vpn_q,
                         ppn: mmu_resp_addr[VADDR_W-1:PAGE_SHIFT], perms: resp_perms};
   assign unused_ok  = ^{mmu_resp_addr[PAGE_SHIFT-1:0], hit_entry};

   tlb_cam #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_cam (
      .clk          (clk),
      .reset        (reset),
      .lookup_vpn_i (lookup_vpn),
      .clear_i      (flush_any),
      .wr_en_i      (wr_en),
      .wr_idx_i     (victim_q),
      .wr_entry_i   (wr_entry),
      .hit_vec_o    (hit_vec),
      .hit_entry_o  (hit_entry)
   );

   assign perm_ok = (!lookup_is_exec  || hit_entry.perms.x) &&
                    (!lookup_is_write || hit_entry.perms.w) &&
                    (lookup_is_exec || lookup_is_write || hit_entry.perms.r);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         req_vpn_q <= '0;
         victim_q  <= '0;
      end else begin
         state_q   <= state_d;
         req_vpn_q <= req_vpn_d;
         victim_q  <= victim_d;
      end
   end

   // Tracked through reset too, so only a genuine root change triggers a flush
   always_ff @(posedge clk) root_q <= root_pt_addr;

   always_comb begin
      state_d      = state_q;
      req_vpn_d    = req_vpn_q;
      victim_d     = victim_q;
      wr_en        = 1'b0;
      resp_valid_c = 1'b0;
      resp_fault_c = 1'b0;
      resp_paddr_c = '0;
      case (state_q)
         ST_IDLE: begin
            if (lookup_valid) begin
               if (|hit_vec) begin
                  resp_valid_c = 1'b1;
                  resp_fault_c = !perm_ok;
                  resp_paddr_c = {hit_entry.ppn, lookup_vaddr[PAGE_SHIFT-1:0]};
               end else begin
                  req_vpn_d = lookup_vpn;
                  state_d   = ST_WALK;
               end
            end
         end
         ST_WALK: begin
            // A response racing a flush belongs to the old translation context
            if (mmu_resp_valid) begin
               if (flush_any) begin
                  state_d = ST_IDLE;
               end else if (resp_perms.v) begin
                  wr_en    = 1'b1;
                  victim_d = victim_q + IDX_W'(1);
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            if (lookup_valid && (lookup_vpn == req_vpn_q)) begin
               resp_valid_c = 1'b1;
               resp_fault_c = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign lookup_resp_valid = resp_valid_c & ~reset;
   assign lookup_fault      = resp_fault_c & ~reset;
   assign lookup_paddr      = reset ? '0 : resp_paddr_c;
   assign mmu_req_valid     = (state_q == ST_WALK);
   assign mmu_req_addr      = mmu_req_valid ? {req_vpn_q, {PAGE_SHIFT{1'b0}}} : '0;

endmodule
